// File: rtl/updown_counter_mod.sv
// Parametrised modulo up/down counter with runtime limit, programmable step,
// and wrap or saturate behaviour at the bounds.
module updown_counter_mod #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              count_en,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  out,
  output logic              wrap,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  logic [XW-1:0] cur_x, lim_x, mod_x, step_x, s_x;
  logic [XW-1:0] sum_x, down_wrap_x;

  // One extra bit so limit+1 and out+s never truncate, even at limit = 2^WIDTH-1.
  assign cur_x       = XW'(out_q);
  assign lim_x       = XW'(limit);
  assign mod_x       = lim_x + XW'(1);
  assign step_x      = XW'(step);
  assign s_x         = (step_x > lim_x) ? lim_x : step_x;
  assign sum_x       = cur_x + s_x;
  assign down_wrap_x = cur_x + mod_x - s_x;

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (clear) begin
      out_d = '0;
    end else if (load) begin
      out_d = (data_in > limit) ? limit : data_in;
    end else if (count_en) begin
      if (cur_x > lim_x) begin
        // Limit was lowered below the current count: pull back, no step.
        out_d = limit;
      end else if (s_x != '0) begin
        if (inc) begin
          if (sum_x <= lim_x) begin
            out_d = WIDTH'(sum_x);
          end else if (sat_mode) begin
            out_d = limit;
          end else begin
            out_d  = WIDTH'(sum_x - mod_x);
            wrap_d = 1'b1;
          end
        end else begin
          if (cur_x >= s_x) begin
            out_d = WIDTH'(cur_x - s_x);
          end else if (sat_mode) begin
            out_d = '0;
          end else begin
            out_d  = WIDTH'(down_wrap_x);
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out    = out_q;
  assign wrap   = wrap_q;
  assign at_max = (out_q == limit);
  assign at_min = (out_q == '0);

endmodule
